// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK stage sequencer for the 18-bit CPU datapath.
// Optional single-step mode: define SINGLE_STEP_EN to add the Step input and the STEP_WAIT stop after each retire.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 8,
  parameter int CNT_W        = 16
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic             OpIsHalt,
  input  logic             OpIsJump,
  input  logic             OpIsLoad,
  input  logic             OpIsStore,
`ifdef SINGLE_STEP_EN
  input  logic             Step,
`endif
  input  logic             MemReady,
  output logic             IRLoad,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       State,
  output logic             Halted,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_STEP_WAIT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_JUMP  = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_HALT  = 3'd4
  } op_class_t;

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

`ifdef SINGLE_STEP_EN
  localparam state_t RETIRE_STATE = S_STEP_WAIT;
`else
  localparam state_t RETIRE_STATE = S_FETCH;
`endif

  state_t            state;
  state_t            state_next;
  op_class_t         op_class;
  op_class_t         op_class_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              timeout_set;
  logic              timeout;
  logic [CNT_W-1:0]  retire_count;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state        <= S_IDLE;
      op_class     <= C_ALU;
      wait_cnt     <= '0;
      timeout      <= 1'b0;
      retire_count <= '0;
    end else begin
      state    <= state_next;
      op_class <= op_class_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_set) begin
        timeout <= 1'b1;
      end
      if (PCWrite) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

  // RAM handshake: MemRead/MemWrite is a request held steady for the whole MEMORY
  // stay; the RAM completes it in any cycle where it samples MemReady=1 alongside the
  // request. After MEM_WAIT_MAX request cycles without MemReady the request is abandoned.
  always_comb begin
    state_next    = state;
    op_class_next = op_class;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (OpIsHalt) begin
          op_class_next = C_HALT;
          state_next    = S_HALT;
        end else begin
          state_next = S_EXECUTE;
          if (OpIsJump) begin
            op_class_next = C_JUMP;
          end else if (OpIsLoad) begin
            op_class_next = C_LOAD;
          end else if (OpIsStore) begin
            op_class_next = C_STORE;
          end else begin
            op_class_next = C_ALU;
          end
        end
      end
      S_EXECUTE: begin
        case (op_class)
          C_JUMP: begin
            state_next = RETIRE_STATE;
          end
          C_LOAD, C_STORE: begin
            state_next    = S_MEMORY;
            wait_cnt_next = '0;
          end
          default: begin
            state_next = S_WRITEBACK;
          end
        endcase
      end
      S_MEMORY: begin
        if (MemReady) begin
          state_next = (op_class == C_STORE) ? RETIRE_STATE : S_WRITEBACK;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_next  = S_HALT;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        state_next = RETIRE_STATE;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      S_STEP_WAIT: begin
`ifdef SINGLE_STEP_EN
        if (Step) begin
          state_next = S_FETCH;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decode from state and registered class. The one exception is the store
  // retire: PC advances in the very cycle the RAM accepts the write.
  always_comb begin
    IRLoad   = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Halted   = 1'b0;
    case (state)
      S_FETCH: begin
        IRLoad = 1'b1;
      end
      S_EXECUTE: begin
        PCWrite = (op_class == C_JUMP);
      end
      S_MEMORY: begin
        MemRead  = (op_class == C_LOAD);
        MemWrite = (op_class == C_STORE);
        PCWrite  = (op_class == C_STORE) && MemReady;
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        MemToReg = (op_class == C_LOAD);
        PCWrite  = 1'b1;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        IRLoad = 1'b0;
      end
    endcase
  end

  assign State       = state;
  assign MemTimeout  = timeout;
  assign RetireCount = retire_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle output checks plus a retire-count scoreboard.
// A second instance with CNT_W=4 shares all inputs to exercise RetireCount wrap.
module tb_multicycle_sequencer;

  localparam int MEM_WAIT_MAX = 8;
  localparam int CNT_W        = 16;
  localparam int CNT_W_SMALL  = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_STEP_WAIT = 3'd7;

  localparam int K_ALU       = 0;
  localparam int K_JUMP      = 1;
  localparam int K_LOAD      = 2;
  localparam int K_STORE     = 3;
  localparam int K_HALT      = 4;
  localparam int K_JUMP_LOAD = 5;

  logic Clock = 1'b0;
  logic Clear, Start, OpIsHalt, OpIsJump, OpIsLoad, OpIsStore, MemReady;
`ifdef SINGLE_STEP_EN
  logic Step;
`endif
  logic IRLoad, PCWrite, RegWrite, MemToReg, MemRead, MemWrite, Halted, MemTimeout;
  logic [2:0] State;
  logic [CNT_W-1:0] RetireCount;
  logic w_IRLoad, w_PCWrite, w_RegWrite, w_MemToReg, w_MemRead, w_MemWrite, w_Halted, w_MemTimeout;
  logic [2:0] w_State;
  logic [CNT_W_SMALL-1:0] w_RetireCount;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_count = '0;
  logic exp_timeout = 1'b0;
  int step_hold = 10;

  multicycle_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start),
    .OpIsHalt(OpIsHalt), .OpIsJump(OpIsJump), .OpIsLoad(OpIsLoad), .OpIsStore(OpIsStore),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .MemReady(MemReady),
    .IRLoad(IRLoad), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .State(State), .Halted(Halted),
    .MemTimeout(MemTimeout), .RetireCount(RetireCount)
  );

  multicycle_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .CNT_W(CNT_W_SMALL)) dut_w (
    .Clock(Clock), .Clear(Clear), .Start(Start),
    .OpIsHalt(OpIsHalt), .OpIsJump(OpIsJump), .OpIsLoad(OpIsLoad), .OpIsStore(OpIsStore),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .MemReady(MemReady),
    .IRLoad(w_IRLoad), .PCWrite(w_PCWrite), .RegWrite(w_RegWrite), .MemToReg(w_MemToReg),
    .MemRead(w_MemRead), .MemWrite(w_MemWrite), .State(w_State), .Halted(w_Halted),
    .MemTimeout(w_MemTimeout), .RetireCount(w_RetireCount)
  );

  // Clock/reset block: 10-unit period; Clear is driven by the directed sequence below.
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [2:0] st, input logic ir, input logic pc,
                                     input logic rw, input logic m2r, input logic rd,
                                     input logic wr, input logic h);
    return {st, ir, pc, rw, m2r, rd, wr, h, exp_timeout};
  endfunction

  task automatic check_outs(input string tag, input logic [10:0] exp);
    check(tag, {21'b0, State, IRLoad, PCWrite, RegWrite, MemToReg, MemRead, MemWrite,
                Halted, MemTimeout}, {21'b0, exp});
    check({tag, "_w"}, {21'b0, w_State, w_IRLoad, w_PCWrite, w_RegWrite, w_MemToReg,
                        w_MemRead, w_MemWrite, w_Halted, w_MemTimeout}, {21'b0, exp});
  endtask

  task automatic next_cycle();
    @(negedge Clock);
  endtask

  task automatic scramble_inputs();
    OpIsHalt  = 1'($urandom_range(0, 1));
    OpIsJump  = 1'($urandom_range(0, 1));
    OpIsLoad  = 1'($urandom_range(0, 1));
    OpIsStore = 1'($urandom_range(0, 1));
    MemReady  = 1'($urandom_range(0, 1));
  endtask

  // Called one cycle after a PCWrite cycle: the count has just advanced.
  task automatic retire_check(input string tag);
    logic [CNT_W-1:0] e;
    check({tag, "_queue"}, {31'b0, exp_q.size() != 0}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_count;
    check({tag, "_count"}, {16'b0, RetireCount}, {16'b0, e});
    check({tag, "_count_w"}, {28'b0, w_RetireCount}, {28'b0, e[CNT_W_SMALL-1:0]});
`ifdef SINGLE_STEP_EN
    check_outs({tag, "_step_wait"}, mk(S_STEP_WAIT, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < step_hold; i++) begin
      next_cycle();
      #1;
      check_outs("step_hold", mk(S_STEP_WAIT, 0, 0, 0, 0, 0, 0, 0));
    end
    step_hold = 1;
    Step = 1'b1;
    next_cycle();
    Step = 1'b0;
`endif
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves with the DUT in FETCH,
  // or in HALT for halt/timeout instructions.
  task automatic do_instr(input int kind, input int w);
    logic is_halt, is_jump, is_load, is_store, is_to;
    OpIsHalt  = (kind == K_HALT);
    OpIsJump  = (kind == K_JUMP) || (kind == K_JUMP_LOAD);
    OpIsLoad  = (kind == K_LOAD) || (kind == K_JUMP_LOAD);
    OpIsStore = (kind == K_STORE);
    MemReady  = 1'($urandom_range(0, 1));
    is_halt  = OpIsHalt;
    is_jump  = !is_halt && OpIsJump;
    is_load  = !is_halt && !is_jump && OpIsLoad;
    is_store = !is_halt && !is_jump && !is_load && OpIsStore;
    is_to    = (is_load || is_store) && (w >= MEM_WAIT_MAX);
    if (!is_halt && !is_to) begin
      exp_count = exp_count + 1'b1;
      exp_q.push_back(exp_count);
    end
    #1;
    check_outs("fetch", mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0));
    next_cycle();
    #1;
    check_outs("decode", mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    scramble_inputs();
    #1;
    if (is_halt) begin
      check_outs("halt_instr", mk(S_HALT, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    check_outs("execute", mk(S_EXECUTE, 0, is_jump, 0, 0, 0, 0, 0));
    if (is_jump) begin
      next_cycle();
      #1;
      retire_check("jump");
      return;
    end
    if (is_load || is_store) begin
      for (int i = 0; i < (is_to ? MEM_WAIT_MAX : w); i++) begin
        next_cycle();
        MemReady = 1'b0;
        #1;
        check_outs("mem_wait", mk(S_MEMORY, 0, 0, 0, 0, is_load, is_store, 0));
      end
      if (is_to) begin
        next_cycle();
        scramble_inputs();
        exp_timeout = 1'b1;
        #1;
        check_outs("mem_timeout", mk(S_HALT, 0, 0, 0, 0, 0, 0, 1));
        check("timeout_count", {16'b0, RetireCount}, {16'b0, exp_count});
        return;
      end
      next_cycle();
      MemReady = 1'b1;
      #1;
      check_outs("mem_done", mk(S_MEMORY, 0, is_store, 0, 0, is_load, is_store, 0));
      if (is_store) begin
        next_cycle();
        scramble_inputs();
        #1;
        retire_check("store");
        return;
      end
    end
    next_cycle();
    scramble_inputs();
    #1;
    check_outs("writeback", mk(S_WRITEBACK, 0, 1, 1, is_load, 0, 0, 0));
    next_cycle();
    #1;
    retire_check("writeback");
  endtask

  task automatic do_clear(input int cycles);
    Clear = 1'b1;
    Start = 1'b0;
    repeat (cycles) next_cycle();
    Clear = 1'b0;
    exp_count = '0;
    exp_q.delete();
    exp_timeout = 1'b0;
    #1;
    check_outs("clear", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0));
    check("clear_count", {16'b0, RetireCount}, 32'd0);
    check("clear_count_w", {28'b0, w_RetireCount}, 32'd0);
  endtask

  task automatic do_start();
    Start = 1'b1;
    next_cycle();
    Start = 1'b0;
  endtask

  task automatic start_ignored_in_halt();
    Start = 1'b1;
    repeat (3) next_cycle();
    #1;
    check_outs("halt_start_ignored", mk(S_HALT, 0, 0, 0, 0, 0, 0, 1));
    Start = 1'b0;
  endtask

  initial begin
    Clear = 1'b1;
    Start = 1'b0;
    OpIsHalt = 1'b0;
    OpIsJump = 1'b0;
    OpIsLoad = 1'b0;
    OpIsStore = 1'b0;
    MemReady = 1'b0;
`ifdef SINGLE_STEP_EN
    Step = 1'b0;
`endif
    next_cycle();
    do_clear(2);

    // Instruction mix, including multi-flag decode and the last-cycle MemReady.
    do_start();
    do_instr(K_ALU, 0);
    do_instr(K_LOAD, 3);
    do_instr(K_JUMP_LOAD, 0);
    do_instr(K_STORE, 0);
    do_instr(K_LOAD, MEM_WAIT_MAX - 1);
    do_instr(K_STORE, 2);
    do_instr(K_JUMP, 0);
    do_instr(K_ALU, 0);
    do_instr(K_HALT, 0);
    start_ignored_in_halt();
    do_clear(1);

    // Store that never completes.
    do_start();
    do_instr(K_STORE, MEM_WAIT_MAX);
    start_ignored_in_halt();
    do_clear(1);

    // Clear during a pending store, even with MemReady high, aborts without retire.
    do_start();
    do_instr(K_ALU, 0);
    OpIsHalt = 1'b0;
    OpIsJump = 1'b0;
    OpIsLoad = 1'b0;
    OpIsStore = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    MemReady = 1'b0;
    #1;
    check_outs("abort_mem", mk(S_MEMORY, 0, 0, 0, 0, 0, 1, 0));
    MemReady = 1'b1;
    do_clear(1);
    MemReady = 1'b0;

    // Sixteen ALU retires wrap the 4-bit counter.
    do_start();
    for (int i = 0; i < 16; i++) begin
      do_instr(K_ALU, 0);
    end
    check("wrap_count_w", {28'b0, w_RetireCount}, 32'd0);
    check("wrap_count", {16'b0, RetireCount}, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
